// File: rtl/mult_div_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : mult_div_unit_if                                           |
// | Description : Start/operand/result bundle between the control unit and   |
// |               the sequential multiply/divide unit.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface mult_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              mult_control;
  logic              DivOp;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;
  logic              mult_end;
  logic              div_end;
  logic              div_zero;
  logic              busy;

  // Control-unit side: issues starts and operands, samples results.
  modport master (
    output mult_control, DivOp, A, B,
    input  HI, LO, mult_end, div_end, div_zero, busy
  );

  // Arithmetic-unit side.
  modport slave (
    input  mult_control, DivOp, A, B,
    output HI, LO, mult_end, div_end, div_zero, busy
  );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_div_unit                                              |
// | Description : Sequential signed multiply (Booth radix-2) and restoring   |
// |               signed divide, DATA_W iterations, one-cycle end pulses.    |
// |               Optional macro MULT_SINGLE_CYCLE_EN replaces the Booth     |
// |               loop with one registered full-width multiply.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset_in,
  mult_div_unit_if.slave bus
);

  localparam int                c_cnt_w     = $clog2(DATA_W) + 1;
  localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MULT   = 3'd1,
    S_DIV    = 3'd2,
    S_DONE   = 3'd3,
    S_DONE_Z = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_count;
  logic               r_is_mult;

  // Multiply working set: {acc, q, q-1}; acc carries one guard bit.
  logic [DATA_W:0]    r_acc;
  logic [DATA_W-1:0]  r_q;
  logic               r_qm1;
  logic [DATA_W-1:0]  r_mcand;

  // Divide working set: magnitudes plus the result signs.
  logic [DATA_W-1:0]  r_rem;
  logic [DATA_W-1:0]  r_quo;
  logic [DATA_W-1:0]  r_dvs;
  logic               r_neg_q;
  logic               r_neg_r;

  // Registered outputs.
  logic [DATA_W-1:0]  r_hi;
  logic [DATA_W-1:0]  r_lo;
  logic               r_mult_end;
  logic               r_div_end;
  logic               r_div_zero;
  logic               r_busy;

  // Operand magnitudes; -2^(DATA_W-1) maps onto itself, which is its
  // correct unsigned magnitude.
  logic [DATA_W-1:0]  w_abs_a;
  logic [DATA_W-1:0]  w_abs_b;
  assign w_abs_a = bus.A[DATA_W-1] ? -bus.A : bus.A;
  assign w_abs_b = bus.B[DATA_W-1] ? -bus.B : bus.B;

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  // The shifted remainder needs one extra bit before the compare; when the
  // subtraction succeeds the difference always fits back into DATA_W bits.
  logic [DATA_W:0]    w_rem_sh;
  logic [DATA_W-1:0]  w_div_diff;
  logic               w_div_ge;
  assign w_rem_sh   = {r_rem, r_quo[DATA_W-1]};
  assign w_div_ge   = (w_rem_sh >= {1'b0, r_dvs});
  assign w_div_diff = w_rem_sh[DATA_W-1:0] - r_dvs;

`ifdef MULT_SINGLE_CYCLE_EN
  // Full signed product in a single registered step.
  logic signed [2*DATA_W-1:0] w_prod;
  assign w_prod = $signed(r_mcand) * $signed(r_q);
`else
  // Booth add/subtract on the guarded accumulator, so M = -2^(DATA_W-1)
  // cannot overflow.
  logic [DATA_W:0]    w_m_ext;
  logic [DATA_W:0]    w_booth_sum;
  assign w_m_ext = {r_mcand[DATA_W-1], r_mcand};

  // Select acc+M, acc-M or acc from the {q0, q-1} pair.
  always_comb begin
    w_booth_sum = r_acc;
    if (r_q[0] && !r_qm1) begin
      w_booth_sum = r_acc - w_m_ext;
    end else if (!r_q[0] && r_qm1) begin
      w_booth_sum = r_acc + w_m_ext;
    end
  end
`endif

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_is_mult  <= 1'b0;
      r_acc      <= '0;
      r_q        <= '0;
      r_qm1      <= 1'b0;
      r_mcand    <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mult_end <= 1'b0;
      r_div_end  <= 1'b0;
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_mult_end <= 1'b0;
      r_div_end  <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Multiply has priority over divide when both are requested.
          if (bus.mult_control) begin
            r_mcand   <= bus.A;
            r_acc     <= '0;
            r_q       <= bus.B;
            r_qm1     <= 1'b0;
            r_count   <= '0;
            r_is_mult <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_MULT;
          end else if (bus.DivOp) begin
            r_busy <= 1'b1;
            if (bus.B == '0) begin
              r_state <= S_DONE_Z;
            end else begin
              r_rem     <= '0;
              r_quo     <= w_abs_a;
              r_dvs     <= w_abs_b;
              r_neg_q   <= bus.A[DATA_W-1] ^ bus.B[DATA_W-1];
              r_neg_r   <= bus.A[DATA_W-1];
              r_count   <= '0;
              r_is_mult <= 1'b0;
              r_state   <= S_DIV;
            end
          end
        end

        S_MULT: begin
`ifdef MULT_SINGLE_CYCLE_EN
          {r_acc, r_q} <= {w_prod[2*DATA_W-1], w_prod};
          r_state      <= S_DONE;
`else
          r_acc   <= {w_booth_sum[DATA_W], w_booth_sum[DATA_W:1]};
          r_q     <= {w_booth_sum[0], r_q[DATA_W-1:1]};
          r_qm1   <= r_q[0];
          r_count <= r_count + 1'b1;
          if (r_count == c_last_iter) begin
            r_state <= S_DONE;
          end
`endif
        end

        S_DIV: begin
          r_rem   <= w_div_ge ? w_div_diff : w_rem_sh[DATA_W-1:0];
          r_quo   <= {r_quo[DATA_W-2:0], w_div_ge};
          r_count <= r_count + 1'b1;
          if (r_count == c_last_iter) begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          if (r_is_mult) begin
            r_hi       <= r_acc[DATA_W-1:0];
            r_lo       <= r_q;
            r_mult_end <= 1'b1;
          end else begin
            // Quotient truncates toward zero; remainder follows the dividend.
            r_lo      <= r_neg_q ? -r_quo : r_quo;
            r_hi      <= r_neg_r ? -r_rem : r_rem;
            r_div_end <= 1'b1;
          end
          r_count <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        S_DONE_Z: begin
          r_div_zero <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.HI       = r_hi;
  assign bus.LO       = r_lo;
  assign bus.mult_end = r_mult_end;
  assign bus.div_end  = r_div_end;
  assign bus.div_zero = r_div_zero;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mult_div_unit                                           |
// | Description : Directed + small random bench for mult_div_unit with an    |
// |               expected-result queue.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mult_div_unit;

`ifdef MULT_SINGLE_CYCLE_EN
  localparam int c_mult_lat = 2;
`else
  localparam int c_mult_lat = 33;
`endif
  localparam int c_div_lat  = 33;
  localparam int c_zero_lat = 1;

  localparam int K_MULT = 0;
  localparam int K_DIV  = 1;
  localparam int K_ZERO = 2;

  typedef struct {
    int          kind;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk;
  logic reset_in;
  int   edge_cnt;
  int   e0;
  int   n_tests;
  int   n_fail;
  logic [31:0] last_hi;
  logic [31:0] last_lo;
  exp_t sb[$];

  mult_div_unit_if #(.DATA_W(32)) bus ();

  mult_div_unit #(.DATA_W(32)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so latency is measured in edges after the start edge.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int kind, input logic [31:0] hi, input logic [31:0] lo,
                          input int lat);
    exp_t e;
    e.kind = kind;
    e.hi   = (kind == K_ZERO) ? last_hi : hi;
    e.lo   = (kind == K_ZERO) ? last_lo : lo;
    e.lat  = lat;
    sb.push_back(e);
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  // Drive a one-cycle start; returns at the falling edge after the start edge.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
    @(negedge clk);
    bus.mult_control = m;
    bus.DivOp        = d;
    bus.A            = a;
    bus.B            = b;
    @(negedge clk);
    e0 = edge_cnt;
    bus.mult_control = 1'b0;
    bus.DivOp        = 1'b0;
    check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
  endtask

  // Wait (bounded) for any end pulse and compare it with the queue head.
  task automatic wait_result(input string tag);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    if (sb.size() == 0) begin
      e.kind = -1; e.hi = '0; e.lo = '0; e.lat = -1;
    end else begin
      e = sb.pop_front();
    end
    while (!seen && (edge_cnt - e0) < 100) begin
      if (bus.mult_end || bus.div_end || bus.div_zero) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_pulse_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(edge_cnt - e0), 64'(e.lat));
    check({tag, "_kind"}, {61'd0, bus.div_zero, bus.div_end, bus.mult_end},
          64'(1 << e.kind));
    check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    check({tag, "_hi"}, 64'(bus.HI), 64'(e.hi));
    check({tag, "_lo"}, 64'(bus.LO), 64'(e.lo));
    @(negedge clk);
    check({tag, "_pulse_width"}, {61'd0, bus.div_zero, bus.div_end, bus.mult_end}, 64'd0);
  endtask

  // Watch for stray pulses over a window.
  task automatic no_pulse(input int cycles, input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.mult_end || bus.div_end || bus.div_zero) cnt++;
    end
    check({tag, "_no_pulse"}, 64'(cnt), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    longint      sa, sbv, p, q, r;
    n_tests = 0;
    n_fail  = 0;
    last_hi = '0;
    last_lo = '0;
    bus.mult_control = 1'b0;
    bus.DivOp        = 1'b0;
    bus.A            = '0;
    bus.B            = '0;
    reset_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {bus.HI, bus.LO},
          64'd0);
    check("rst_flags", {60'd0, bus.busy, bus.div_zero, bus.div_end, bus.mult_end}, 64'd0);
    reset_in = 1'b0;

    // 7 * -3
    push_exp(K_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, c_mult_lat);
    start_op(1'b1, 1'b0, 32'd7, -32'sd3, "mul_7_m3");
    wait_result("mul_7_m3");

    // -2^31 * -2^31
    push_exp(K_MULT, 32'h4000_0000, 32'h0000_0000, c_mult_lat);
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, "mul_min_min");
    wait_result("mul_min_min");

    // -7 / 2
    push_exp(K_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFD, c_div_lat);
    start_op(1'b0, 1'b1, -32'sd7, 32'd2, "div_m7_2");
    wait_result("div_m7_2");

    // -2^31 / -1 wraps without a trap
    push_exp(K_DIV, 32'h0000_0000, 32'h8000_0000, c_div_lat);
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    wait_result("div_min_m1");

    // divide by zero: pulse after one edge, HI/LO keep previous result
    push_exp(K_ZERO, '0, '0, c_zero_lat);
    start_op(1'b0, 1'b1, 32'd5, 32'd0, "div_zero");
    wait_result("div_zero");
    no_pulse(40, "div_zero_after");

    // both starts high: multiply wins
    push_exp(K_MULT, 32'd0, 32'd24, c_mult_lat);
    start_op(1'b1, 1'b1, 32'd6, 32'd4, "both_start");
    wait_result("both_start");
    no_pulse(40, "both_start_after");

    // DivOp while busy is ignored
    push_exp(K_MULT, 32'hFFFF_FFFF, 32'hFFFF_FF9C, c_mult_lat);
    start_op(1'b1, 1'b0, -32'sd10, 32'd10, "busy_div");
    bus.DivOp = 1'b1;
    bus.B     = 32'd3;
    @(negedge clk);
    bus.DivOp = 1'b0;
    wait_result("busy_div");
    no_pulse(40, "busy_div_after");

    // model-checked random operations
    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      if (rb == 32'd0) rb = 32'd1;
      sa  = longint'($signed(ra));
      sbv = longint'($signed(rb));
      if (i % 2 == 0) begin
        p = sa * sbv;
        push_exp(K_MULT, p[63:32], p[31:0], c_mult_lat);
        start_op(1'b1, 1'b0, ra, rb, "rnd_mul");
        wait_result("rnd_mul");
      end else begin
        q = sa / sbv;
        r = sa % sbv;
        push_exp(K_DIV, r[31:0], q[31:0], c_div_lat);
        start_op(1'b0, 1'b1, ra, rb, "rnd_div");
        wait_result("rnd_div");
      end
    end

    // reset at iteration 10 of a divide aborts it silently
    start_op(1'b0, 1'b1, 32'd1000, 32'd7, "abort");
    repeat (9) @(negedge clk);
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    check("abort_hilo", {bus.HI, bus.LO}, 64'd0);
    check("abort_flags", {60'd0, bus.busy, bus.div_zero, bus.div_end, bus.mult_end}, 64'd0);
    last_hi = '0;
    last_lo = '0;
    no_pulse(40, "abort_after");

    push_exp(K_MULT, 32'd0, 32'd12, c_mult_lat);
    start_op(1'b1, 1'b0, 32'd3, 32'd4, "mul_3_4");
    wait_result("mul_3_4");

    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
